oam_dma_engine: RTL and testbench

- Parametrised successor to the fixed 256-byte sprite DMA: a general CPU-stalling block-copy engine sitting between the CPU address bus and the hardware decoder.
- A CPU write of page byte P to TRIGGER_ADDR copies XFER_LEN bytes from {P, 8'h00} onward to the fixed DEST_ADDR. A sprite copy to the PPU OAM data port is one example.
- When idle, the block is a transparent address/strobe pass-through. While copying, it owns the bus and holds the CPU stalled.

---
 rtl/oam_dma_engine.sv | 150 +++++++++++++++
 tb/tb_oam_dma_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: CPU-stalling block-copy engine between the CPU bus and the
// hardware decoder. A CPU write of page byte P to TRIGGER_ADDR copies XFER_LEN
// bytes from {P, 8'h00} onward to DEST_ADDR, one READ/WRITE pair per byte.
// Idle: transparent combinational pass-through of CPU address/strobes/data.
// Optional macro OAM_DMA_ABORT_EN adds the abort input and aborted pulse.
module oam_dma_engine #(
  parameter int unsigned         ADDR_W       = 16,
  parameter int unsigned         DATA_W       = 8,
  parameter logic [ADDR_W-1:0]   TRIGGER_ADDR = 16'h4014,
  parameter logic [ADDR_W-1:0]   DEST_ADDR    = 16'h2004,
  parameter int unsigned         XFER_LEN     = 256,
  parameter int unsigned         ALIGN_EN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done
`ifdef OAM_DMA_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  localparam int unsigned CNT_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t            state, state_d;
  logic              parity;
  logic [7:0]        page, page_d;
  logic [CNT_W-1:0]  count, count_d;
  logic [DATA_W-1:0] latch, latch_d;
  logic              done_d;
  logic [7:0]        offset;
  logic              trigger;

  assign offset  = 8'(count);
  assign trigger = cpu_wr && (cpu_addr == TRIGGER_ADDR);

`ifdef OAM_DMA_ABORT_EN
  logic abort_go;
  // Abort takes effect in HALT/ALIGN/READ, or after any non-final WRITE.
  assign abort_go = abort && ((state == S_HALT) || (state == S_ALIGN) ||
                              (state == S_READ) ||
                              ((state == S_WRITE) && (count != LAST)));

  // Registered one-cycle aborted pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= abort_go;
  end
`else
  localparam logic abort_go = 1'b0;
`endif

  // State, parity and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      parity <= 1'b0;
      page   <= '0;
      count  <= '0;
      latch  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      parity <= ~parity;
      page   <= page_d;
      count  <= count_d;
      latch  <= latch_d;
      done   <= done_d;
    end
  end

  // Next-state logic and bus ownership mux.
  always_comb begin
    state_d   = state;
    page_d    = page;
    count_d   = count;
    latch_d   = latch;
    done_d    = 1'b0;
    bus_addr  = cpu_addr;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = cpu_wdata;
    unique case (state)
      S_IDLE: begin
        bus_rd = cpu_rd;
        bus_wr = cpu_wr;
        if (trigger) begin
          page_d  = cpu_wdata[7:0];
          count_d = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (abort_go)                      state_d = S_IDLE;
        else if ((ALIGN_EN != 0) && parity) state_d = S_ALIGN;
        else                               state_d = S_READ;
      end
      S_ALIGN: begin
        state_d = abort_go ? S_IDLE : S_READ;
      end
      S_READ: begin
        bus_addr = ADDR_W'({page, offset});
        bus_rd   = 1'b1;
        latch_d  = bus_rdata;
        state_d  = abort_go ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        bus_addr  = DEST_ADDR;
        bus_wr    = 1'b1;
        bus_wdata = latch;
        if (count == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (abort_go) begin
          state_d = S_IDLE;
        end else begin
          count_d = count + CNT_W'(1);
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall and busy cover every non-idle state.
  assign cpu_stall = (state != S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_oam_dma_engine.sv
// Self-checking bench for oam_dma_engine: three instances (256/align, 4/no
// align, 1/align) against a byte-level reference of the copy.
module tb_oam_dma_engine;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;

  logic        clk, rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr_v    [3];
  logic [7:0]  rdata_v     [3];
  logic [15:0] bus_addr_v  [3];
  logic        bus_rd_v    [3];
  logic        bus_wr_v    [3];
  logic [7:0]  bus_wdata_v [3];
  logic        stall_v     [3];
  logic        busy_v      [3];
  logic        done_v      [3];
  logic        abort_v     [3];
  logic        aborted_v   [3];

  logic [7:0]  mem [0:65535];
  int          tests, fails, edges, sel;
  logic [7:0]  wq[$];
  logic [15:0] rq[$];
  int          stall_n, done_n, abrt_n, bad_wr, stall_at_done;

  oam_dma_engine u_a (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr_v[0]),
    .cpu_wdata(cpu_wdata), .bus_rdata(rdata_v[0]), .bus_addr(bus_addr_v[0]), .bus_rd(bus_rd_v[0]),
    .bus_wr(bus_wr_v[0]), .bus_wdata(bus_wdata_v[0]), .cpu_stall(stall_v[0]), .busy(busy_v[0]),
    .done(done_v[0])
`ifdef OAM_DMA_ABORT_EN
    , .abort(abort_v[0]), .aborted(aborted_v[0])
`endif
  );

  oam_dma_engine #(.XFER_LEN(4), .ALIGN_EN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr_v[1]),
    .cpu_wdata(cpu_wdata), .bus_rdata(rdata_v[1]), .bus_addr(bus_addr_v[1]), .bus_rd(bus_rd_v[1]),
    .bus_wr(bus_wr_v[1]), .bus_wdata(bus_wdata_v[1]), .cpu_stall(stall_v[1]), .busy(busy_v[1]),
    .done(done_v[1])
`ifdef OAM_DMA_ABORT_EN
    , .abort(abort_v[1]), .aborted(aborted_v[1])
`endif
  );

  oam_dma_engine #(.XFER_LEN(1), .ALIGN_EN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr_v[2]),
    .cpu_wdata(cpu_wdata), .bus_rdata(rdata_v[2]), .bus_addr(bus_addr_v[2]), .bus_rd(bus_rd_v[2]),
    .bus_wr(bus_wr_v[2]), .bus_wdata(bus_wdata_v[2]), .cpu_stall(stall_v[2]), .busy(busy_v[2]),
    .done(done_v[2])
`ifdef OAM_DMA_ABORT_EN
    , .abort(abort_v[2]), .aborted(aborted_v[2])
`endif
  );

`ifndef OAM_DMA_ABORT_EN
  assign aborted_v[0] = 1'b0;
  assign aborted_v[1] = 1'b0;
  assign aborted_v[2] = 1'b0;
`endif

  // Memory model seen by all three engines.
  assign rdata_v[0] = mem[bus_addr_v[0]];
  assign rdata_v[1] = mem[bus_addr_v[1]];
  assign rdata_v[2] = mem[bus_addr_v[2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset; the engine's parity bit equals this count mod 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Bus monitor for the instance under test.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_v[sel] && bus_rd_v[sel]) rq.push_back(bus_addr_v[sel]);
      if (busy_v[sel] && bus_wr_v[sel]) begin
        wq.push_back(bus_wdata_v[sel]);
        if (bus_addr_v[sel] !== DEST) bad_wr++;
      end
      if (stall_v[sel]) stall_n++;
      if (done_v[sel]) begin
        done_n++;
        if (stall_v[sel]) stall_at_done++;
      end
      if (aborted_v[sel]) abrt_n++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int k);
    @(posedge clk); #2;
    sel = k; wq.delete(); rq.delete();
    stall_n = 0; done_n = 0; abrt_n = 0; bad_wr = 0; stall_at_done = 0;
  endtask

  // Issue a trigger at a negedge whose parity count is 'want'; returns align.
  task automatic trigger(input int k, input logic [7:0] page, input int want, input bit aen,
                         output bit al);
    int t;
    @(negedge clk);
    while ((edges % 2) != want) @(negedge clk);
    cpu_addr = TRIG; cpu_wdata = page; cpu_wr_v[k] = 1'b1; t = edges;
    @(negedge clk);
    cpu_wr_v[k] = 1'b0;
    cpu_addr = 16'($urandom); cpu_rd = 1'b1;
    al = aen && (((t + 1) % 2) == 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int cyc = 0;
    while (done_n < target && cyc < budget) begin
      @(negedge clk); #1; cyc++;
    end
    cpu_rd = 1'b0;
    chk({tag, " done_seen"}, int'(done_n >= target), 1);
  endtask

  task automatic check_data(input logic [7:0] page, input int len, input int base,
                            input string tag);
    int bad_d = 0, bad_a = 0;
    for (int i = 0; i < len; i++) begin
      logic [15:0] a;
      a = {page, 8'(i)};
      if (base + i >= wq.size() || wq[base + i] !== mem[a]) bad_d++;
      if (base + i >= rq.size() || rq[base + i] !== a) bad_a++;
    end
    chk({tag, " data_mism"}, bad_d, 0);
    chk({tag, " raddr_mism"}, bad_a, 0);
  endtask

  task automatic run_xfer(input int k, input logic [7:0] page, input int len, input bit aen,
                          input int want, input string tag);
    bit al;
    clear_mon(k);
    trigger(k, page, want, aen, al);
    wait_done(1, 2 * len + 20, tag);
    repeat (2) @(negedge clk);
    #1;
    chk({tag, " done_pulses"}, done_n, 1);
    chk({tag, " stall_cycles"}, stall_n, 1 + int'(al) + 2 * len);
    chk({tag, " stall_at_done"}, stall_at_done, 0);
    chk({tag, " writes"}, wq.size(), len);
    chk({tag, " reads"}, rq.size(), len);
    chk({tag, " bad_dest"}, bad_wr, 0);
    check_data(page, len, 0, tag);
  endtask

  initial begin
    bit al;
    logic [7:0] p1, p2;
    int cyc;
    tests = 0; fails = 0; sel = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; cpu_addr = 16'h0; cpu_rd = 1'b0; cpu_wdata = 8'h0;
    for (int k = 0; k < 3; k++) begin cpu_wr_v[k] = 1'b0; abort_v[k] = 1'b0; end
    wq.delete(); rq.delete();
    stall_n = 0; done_n = 0; abrt_n = 0; bad_wr = 0; stall_at_done = 0;

    // Reset state and idle pass-through.
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst stall%0d", k), int'(stall_v[k]), 0);
      chk($sformatf("rst busy%0d", k), int'(busy_v[k]), 0);
      chk($sformatf("rst done%0d", k), int'(done_v[k]), 0);
    end
    @(negedge clk); rst_n = 1'b1;
    cpu_addr = 16'h0123; cpu_rd = 1'b1;
    #1;
    chk("idle bus_addr", int'(bus_addr_v[0]), 16'h0123);
    chk("idle bus_rd", int'(bus_rd_v[0]), 1);
    chk("idle bus_wr", int'(bus_wr_v[0]), 0);
    chk("idle stall", int'(stall_v[0]), 0);
    chk("idle busy", int'(busy_v[0]), 0);
    @(negedge clk);
    cpu_rd = 1'b0; cpu_addr = 16'h0456; cpu_wdata = 8'hC3; cpu_wr_v[0] = 1'b1;
    #1;
    chk("idle wr pass", int'(bus_wr_v[0]), 1);
    chk("idle wdata pass", int'(bus_wdata_v[0]), 8'hC3);
    @(negedge clk); cpu_wr_v[0] = 1'b0;

    // Full 256-byte copies at both parities, fixed and random pages.
    run_xfer(0, 8'h02, 256, 1'b1, 0, "full_p0");
    run_xfer(0, 8'h02, 256, 1'b1, 1, "full_p1");
    run_xfer(0, 8'($urandom), 256, 1'b1, $urandom_range(0, 1), "full_rand");

    // Short length without alignment, and single-byte with alignment.
    run_xfer(1, 8'h03, 4, 1'b0, 0, "len4_p0");
    run_xfer(1, 8'h03, 4, 1'b0, 1, "len4_p1");
    run_xfer(1, 8'($urandom), 4, 1'b0, $urandom_range(0, 1), "len4_rand");
    run_xfer(2, 8'($urandom), 1, 1'b1, 0, "len1_p0");
    run_xfer(2, 8'($urandom), 1, 1'b1, 1, "len1_p1");

    // Back-to-back: second trigger issued in the done cycle.
    p1 = 8'($urandom); p2 = 8'($urandom);
    clear_mon(1);
    trigger(1, p1, 0, 1'b0, al);
    wait_done(1, 40, "b2b first");
    cpu_addr = TRIG; cpu_wdata = p2; cpu_wr_v[1] = 1'b1;
    chk("b2b in_done_cycle", int'(done_v[1]), 1);
    @(negedge clk); cpu_wr_v[1] = 1'b0;
    wait_done(2, 40, "b2b second");
    repeat (2) @(negedge clk);
    #1;
    chk("b2b writes", wq.size(), 8);
    chk("b2b stall", stall_n, 18);
    chk("b2b done_pulses", done_n, 2);
    check_data(p1, 4, 0, "b2b first");
    check_data(p2, 4, 4, "b2b second");

    // Reset mid-transfer at write #100, then restart from offset 0.
    clear_mon(0);
    trigger(0, 8'($urandom), 0, 1'b1, al);
    cyc = 0;
    while (wq.size() < 100 && cyc < 400) begin @(negedge clk); #1; cyc++; end
    cpu_rd = 1'b0;
    chk("rstmid reached_w100", wq.size(), 100);
    rst_n = 1'b0;
    #1;
    chk("rstmid stall", int'(stall_v[0]), 0);
    chk("rstmid busy", int'(busy_v[0]), 0);
    chk("rstmid bus_wr", int'(bus_wr_v[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid no_done", done_n, 0);
    run_xfer(0, 8'($urandom), 256, 1'b1, $urandom_range(0, 1), "after_rst");

`ifdef OAM_DMA_ABORT_EN
    // Abort during read #10: nine writes, one aborted pulse, no done.
    clear_mon(0);
    trigger(0, 8'($urandom), 0, 1'b1, al);
    cyc = 0;
    while (rq.size() < 10 && cyc < 100) begin @(negedge clk); #1; cyc++; end
    cpu_rd = 1'b0;
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    #1;
    chk("abort stall_next", int'(stall_v[0]), 0);
    chk("abort pulse_now", int'(aborted_v[0]), 1);
    repeat (5) @(negedge clk);
    #1;
    chk("abort writes", wq.size(), 9);
    chk("abort pulses", abrt_n, 1);
    chk("abort no_done", done_n, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
